div_unit: RTL and testbench

Iterative 32-bit divider for the RV32M division ops (DIV, DIVU, REM, REMU) that the single-cycle `alu` does not implement. It sits beside `alu` in the EX stage and consumes the same operand pair and the same 4-bit `alu_ctrl` encoding. It produces a registered result with a done pulse, and the pipeline stalls on `busy`. It uses radix-2 restoring division: one quotient bit per cycle, with sign correction at the end.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/div_unit.sv | 178 +++++++++++++++++
 tb/tb_div_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: ALU op encodings used by alu, decoder and div_unit,
// the divider state type, and the machine word width.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_REM  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;
    localparam logic [3:0] ALU_REMU = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    // True for any of the four division-family encodings.
    function automatic logic is_div_op(input logic [3:0] ctrl);
        return (ctrl >= ALU_DIV) && (ctrl <= ALU_REMU);
    endfunction

    // True for the signed variants (DIV, REM).
    function automatic logic is_signed_div(input logic [3:0] ctrl);
        return (ctrl == ALU_DIV) || (ctrl == ALU_REM);
    endfunction

    // True when the remainder rather than the quotient is returned.
    function automatic logic is_rem_op(input logic [3:0] ctrl);
        return (ctrl == ALU_REM) || (ctrl == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes on accept, one quotient bit is produced
// per CALC cycle, and signs / divide-by-zero results are applied in FIN.
module div_unit #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_ctrl,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    import riscv_pkg::*;

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_t         state_r;
    div_state_t         state_nxt_s;
    logic               accept_s;

    logic [CNT_W-1:0]   cnt_r;
    logic [XLEN-1:0]    rem_acc_r;
    logic [XLEN-1:0]    quo_r;
    logic [XLEN-1:0]    divisor_r;
    logic [XLEN-1:0]    a_r;
    logic               rem_op_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               b_zero_r;
    logic [XLEN-1:0]    result_r;
    logic               done_r;
    logic               busy_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [XLEN-1:0]    a_abs_s;
    logic [XLEN-1:0]    b_abs_s;
    logic [XLEN:0]      shift_s;
    logic [XLEN:0]      diff_s;
    logic [XLEN-1:0]    rem_nxt_s;
    logic               qbit_s;
    logic [XLEN-1:0]    q_fix_s;
    logic [XLEN-1:0]    r_fix_s;
    logic [XLEN-1:0]    fin_result_s;

    // State register; reset returns to IDLE and abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero divisor skips the iteration phase entirely.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && is_div_op(alu_ctrl)) begin
                    accept_s    = 1'b1;
                    state_nxt_s = (b == {XLEN{1'b0}}) ? FIN : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand magnitudes and sign flags captured at accept (signed ops only).
    always_comb begin
        a_neg_s = is_signed_div(alu_ctrl) & a[XLEN-1];
        b_neg_s = is_signed_div(alu_ctrl) & b[XLEN-1];
        a_abs_s = a_neg_s ? ({XLEN{1'b0}} - a) : a;
        b_abs_s = b_neg_s ? ({XLEN{1'b0}} - b) : b;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract on XLEN+1 bits.
    always_comb begin
        shift_s = {rem_acc_r, quo_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, divisor_r};
        qbit_s  = ~diff_s[XLEN];
        if (qbit_s) begin
            rem_nxt_s = diff_s[XLEN-1:0];
        end else begin
            rem_nxt_s = shift_s[XLEN-1:0];
        end
    end

    // Final result: sign fix-up, or the architectural divide-by-zero values.
    always_comb begin
        q_fix_s = neg_q_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
        r_fix_s = neg_r_r ? ({XLEN{1'b0}} - rem_acc_r) : rem_acc_r;
        if (b_zero_r) begin
            if (rem_op_r) begin
                fin_result_s = a_r;
            end else begin
                fin_result_s = {XLEN{1'b1}};
            end
        end else begin
            if (rem_op_r) begin
                fin_result_s = r_fix_s;
            end else begin
                fin_result_s = q_fix_s;
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            rem_acc_r <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            divisor_r <= {XLEN{1'b0}};
            a_r       <= {XLEN{1'b0}};
            rem_op_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            b_zero_r  <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        rem_acc_r <= {XLEN{1'b0}};
                        quo_r     <= a_abs_s;
                        divisor_r <= b_abs_s;
                        a_r       <= a;
                        rem_op_r  <= is_rem_op(alu_ctrl);
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_r_r   <= a_neg_s;
                        b_zero_r  <= (b == {XLEN{1'b0}});
                    end
                end
                CALC: begin
                    rem_acc_r <= rem_nxt_s;
                    quo_r     <= {quo_r[XLEN-2:0], qbit_s};
                    cnt_r     <= cnt_r + CNT_W'(1);
                end
                FIN: begin
                    result_r <= fin_result_s;
                    done_r   <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = (result_r == {XLEN{1'b0}});

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic RV32M division model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int n_checks;
    int n_pass;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        sx = x;
        sy = y;
        case (op)
            4'b1001: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                else return 32'(sx / sy);
            end
            4'b1010: begin
                if (y == 32'd0) return x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                else return 32'(sx % sy);
            end
            4'b1011: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                else return x / y;
            end
            4'b1100: begin
                if (y == 32'd0) return x;
                else return x % y;
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one op at posedge+1, then wait (bounded) for done. lat counts edges
    // after the accepting edge; busy_cnt counts cycles busy was high before done.
    // If glitch >= 0 a stray valid start is pulsed for one cycle at that point.
    task automatic do_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input int glitch, output logic [31:0] res, output int lat, output int busy_cnt);
        alu_ctrl = op;
        a        = aa;
        b        = bb;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            start = (lat == glitch);
            if (lat == glitch) alu_ctrl = 4'($urandom_range(9, 12));
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        res = result;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        int lat;
        int bc;
        int done_seen;
        logic [3:0] op;
        logic [31:0] ra;
        logic [31:0] rb;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        alu_ctrl = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed division with a negative dividend.
        do_op(4'b1001, 32'hFFFF_FFF9, 32'd2, -1, r, lat, bc);
        check("div_m7_2", r, 32'hFFFF_FFFD);
        check("div_lat", 32'(lat), 32'd33);
        check("div_busy_low_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        do_op(4'b1010, 32'hFFFF_FFF9, 32'd2, -1, r, lat, bc);
        check("rem_m7_2", r, 32'hFFFF_FFFF);

        // Unsigned ops and busy width.
        do_op(4'b1011, 32'hFFFF_FFFF, 32'd2, -1, r, lat, bc);
        check("divu_max_2", r, 32'h7FFF_FFFF);
        check("divu_busy_cycles", 32'(bc), 32'd33);
        do_op(4'b1100, 32'd100, 32'd7, -1, r, lat, bc);
        check("remu_100_7", r, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("result_held", result, 32'd2);

        // Divide by zero.
        do_op(4'b1001, 32'd5, 32'd0, -1, r, lat, bc);
        check("div_by0", r, 32'hFFFF_FFFF);
        check("div_by0_lat", 32'(lat), 32'd1);
        do_op(4'b1010, 32'd5, 32'd0, -1, r, lat, bc);
        check("rem_by0", r, 32'd5);
        check("rem_by0_lat", 32'(lat), 32'd1);
        do_op(4'b1100, 32'd0, 32'd0, -1, r, lat, bc);
        check("remu_by0", r, 32'd0);
        check("remu_by0_zero", {31'd0, zero}, 32'd1);
        check("remu_by0_lat", 32'(lat), 32'd1);

        // Signed overflow.
        do_op(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF, -1, r, lat, bc);
        check("div_ovf", r, 32'h8000_0000);
        do_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, -1, r, lat, bc);
        check("rem_ovf", r, 32'd0);
        check("rem_ovf_zero", {31'd0, zero}, 32'd1);

        // Stray start mid-CALC is ignored; next op starts in the done cycle.
        do_op(4'b1011, 32'd1000, 32'd10, 5, r, lat, bc);
        check("glitch_ignored", r, 32'd100);
        check("glitch_lat", 32'(lat), 32'd33);
        check("b2b_done_cycle", {31'd0, done}, 32'd1);
        do_op(4'b1011, 32'd9, 32'd3, -1, r, lat, bc);
        check("b2b_divu_9_3", r, 32'd3);
        check("b2b_lat", 32'(lat), 32'd33);

        // Reset in the middle of CALC aborts without a done.
        alu_ctrl = 4'b1001;
        a        = 32'd77;
        b        = 32'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        do_op(4'b1001, 32'd20, 32'hFFFF_FFFC, -1, r, lat, bc);
        check("div_20_m4", r, 32'hFFFF_FFFB);

        // Invalid op encoding is ignored.
        held     = result;
        alu_ctrl = 4'b0000;
        a        = 32'd8;
        b        = 32'd2;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("invalid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("invalid_no_done", {31'd0, done}, 32'd0);
        check("invalid_result_held", result, held);

        // Reset wins over a simultaneous start.
        alu_ctrl = 4'b1011;
        start    = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        check("rst_priority_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Randomized ops against the model.
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(9, 12));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = rb >> $urandom_range(0, 31);
                2:       ra = ra >> $urandom_range(0, 31);
                3:       rb = 32'hFFFF_FFFF;
                default: rb = rb;
            endcase
            do_op(op, ra, rb, -1, r, lat, bc);
            check($sformatf("rand%0d_op%0d", i, op), r, model(op, ra, rb));
            check($sformatf("rand%0d_lat", i), 32'(lat), (rb == 32'd0) ? 32'd1 : 32'd33);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
